// File: rtl/rc_lifm_sequencer.sv
// rc_lifm_sequencer
//   Sequences the redundancy-controller datapath. Walks the LIFM held in
//   on-chip SRAM window by window and, inside a window, kernel index by kernel
//   index. Reads are issued in groups of up to MAX_LIFM_RSIZ columns; each
//   returned column is forwarded with its kidx, and the next group is only
//   issued after the controller answers with rc_valid.
//
// Ports
//   clk, reset          clock (rising edge), synchronous active-high reset
//   start               one-cycle pulse, honoured only while idle
//   num_kidx, num_win   kernel elements per window / window count (latched on start)
//   sram_rd_en/addr     SRAM read strobe and row address
//   sram_rd_data        SRAM read data, valid one cycle after sram_rd_en
//   rc_enable           controller enable (FETCH through WAIT)
//   rc_col_valid        rc_kidx / rc_lifm_column valid this cycle
//   rc_kidx             kernel index of the forwarded column
//   rc_lifm_column      forwarded column (gated copy of sram_rd_data)
//   rc_grp_last         marks the final column of a group
//   rc_valid            controller output-valid, closes the current group
//   busy, done          status to the layer controller
//   timeout_err         only with RC_SEQ_TIMEOUT_EN: sticky WAIT watchdog flag
//
// Build option
//   RC_SEQ_TIMEOUT_EN   adds a 16-bit WAIT watchdog and the timeout_err port.

module rc_lifm_sequencer #(
  parameter int WORD_WIDTH    = 8,
  parameter int STEP_RANGE    = 128,
  parameter int MAX_LIFM_RSIZ = 3,
  parameter int ADDR_WIDTH    = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [WORD_WIDTH-1:0]            num_kidx,
  input  logic [WORD_WIDTH-1:0]            num_win,
  output logic                             sram_rd_en,
  output logic [ADDR_WIDTH-1:0]            sram_rd_addr,
  input  logic [WORD_WIDTH*STEP_RANGE-1:0] sram_rd_data,
  output logic                             rc_enable,
  output logic                             rc_col_valid,
  output logic [WORD_WIDTH-1:0]            rc_kidx,
  output logic [WORD_WIDTH*STEP_RANGE-1:0] rc_lifm_column,
  output logic                             rc_grp_last,
  input  logic                             rc_valid,
  output logic                             busy,
  output logic                             done
`ifdef RC_SEQ_TIMEOUT_EN
  ,
  output logic                             timeout_err
`endif
);

  localparam logic [WORD_WIDTH-1:0] W_ONE        = WORD_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_ONE        = ADDR_WIDTH'(1);
  localparam logic [WORD_WIDTH-1:0] GRP_LAST_IDX = WORD_WIDTH'(MAX_LIFM_RSIZ - 1);

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, WAIT, ADV, FIN} state_t;

  state_t                  state;
  logic [WORD_WIDTH-1:0]   nk_q;
  logic [WORD_WIDTH-1:0]   nw_q;
  logic [WORD_WIDTH-1:0]   kidx_cnt;   // kidx of the read being issued / next to issue
  logic [WORD_WIDTH-1:0]   grp_cnt;    // reads issued since the current group started
  logic [WORD_WIDTH-1:0]   win_cnt;
  logic [ADDR_WIDTH-1:0]   win_base;   // running sum of num_kidx, avoids a multiplier
  logic                    last_rd;
`ifdef RC_SEQ_TIMEOUT_EN
  logic [15:0]             wdog;
`endif

  // A group closes either at its size limit or at the end of the window.
  assign last_rd = (kidx_cnt == nk_q - W_ONE) || (grp_cnt == GRP_LAST_IDX);

  // SRAM data arrives aligned with rc_col_valid; gating keeps the column at
  // zero outside valid cycles, so stale or aborted reads never leak out.
  assign rc_lifm_column = rc_col_valid ? sram_rd_data : '0;

  // Stage p0: read issue / FSM; stage p1: column valid + kidx registers.
  // Read strobe and address are registered, so every transition into FETCH
  // preloads the address of the first read of the new group.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      nk_q         <= '0;
      nw_q         <= '0;
      kidx_cnt     <= '0;
      grp_cnt      <= '0;
      win_cnt      <= '0;
      win_base     <= '0;
      sram_rd_en   <= 1'b0;
      sram_rd_addr <= '0;
      rc_enable    <= 1'b0;
      rc_col_valid <= 1'b0;
      rc_kidx      <= '0;
      rc_grp_last  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
`ifdef RC_SEQ_TIMEOUT_EN
      wdog         <= '0;
      timeout_err  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            nk_q     <= num_kidx;
            nw_q     <= num_win;
            kidx_cnt <= '0;
            grp_cnt  <= '0;
            win_cnt  <= '0;
            win_base <= '0;
            if (num_kidx != '0 && num_win != '0) begin
              state        <= FETCH;
              busy         <= 1'b1;
              rc_enable    <= 1'b1;
              sram_rd_en   <= 1'b1;
              sram_rd_addr <= '0;
            end else begin
              state <= FIN;
              done  <= 1'b1;
            end
          end
        end
        FETCH: begin
          rc_col_valid <= 1'b1;
          rc_kidx      <= kidx_cnt;
          rc_grp_last  <= last_rd;
          kidx_cnt     <= kidx_cnt + W_ONE;
          grp_cnt      <= grp_cnt + W_ONE;
          if (last_rd) begin
            sram_rd_en <= 1'b0;
            state      <= DRAIN;
          end else begin
            sram_rd_addr <= sram_rd_addr + A_ONE;
          end
        end
        DRAIN: begin
          rc_col_valid <= 1'b0;
          rc_grp_last  <= 1'b0;
          state        <= WAIT;
`ifdef RC_SEQ_TIMEOUT_EN
          wdog         <= '0;
`endif
        end
        WAIT: begin
          if (rc_valid) begin
            rc_enable <= 1'b0;
            state     <= ADV;
          end
`ifdef RC_SEQ_TIMEOUT_EN
          else if (wdog == 16'hFFFF) begin
            timeout_err <= 1'b1;
            rc_enable   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= FIN;
          end else begin
            wdog <= wdog + 16'd1;
          end
`endif
        end
        ADV: begin
          grp_cnt <= '0;
          if (kidx_cnt < nk_q) begin
            state        <= FETCH;
            rc_enable    <= 1'b1;
            sram_rd_en   <= 1'b1;
            sram_rd_addr <= win_base + ADDR_WIDTH'(kidx_cnt);
          end else begin
            kidx_cnt <= '0;
            win_cnt  <= win_cnt + W_ONE;
            win_base <= win_base + ADDR_WIDTH'(nk_q);
            if (win_cnt == nw_q - W_ONE) begin
              state <= FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state        <= FETCH;
              rc_enable    <= 1'b1;
              sram_rd_en   <= 1'b1;
              sram_rd_addr <= win_base + ADDR_WIDTH'(nk_q);
            end
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rc_lifm_sequencer.sv
module tb_rc_lifm_sequencer;
  localparam int WW = 8;
  localparam int SR = 128;
  localparam int AW = 16;
  localparam int CW = WW * SR;

  logic          clk = 1'b0;
  logic          reset, start, rc_valid;
  logic [WW-1:0] num_kidx, num_win;
  logic          sram_rd_en, rc_enable, rc_col_valid, rc_grp_last, busy, done;
  logic [AW-1:0] sram_rd_addr;
  logic [CW-1:0] sram_rd_data, rc_lifm_column;
  logic [WW-1:0] rc_kidx;
`ifdef RC_SEQ_TIMEOUT_EN
  logic          timeout_err;
`endif

  always #5 clk = ~clk;

  rc_lifm_sequencer #(
    .WORD_WIDTH(WW), .STEP_RANGE(SR), .MAX_LIFM_RSIZ(3), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .num_kidx(num_kidx), .num_win(num_win),
    .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr), .sram_rd_data(sram_rd_data),
    .rc_enable(rc_enable), .rc_col_valid(rc_col_valid), .rc_kidx(rc_kidx),
    .rc_lifm_column(rc_lifm_column), .rc_grp_last(rc_grp_last),
    .rc_valid(rc_valid), .busy(busy), .done(done)
`ifdef RC_SEQ_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  typedef struct packed {
    logic [7:0]  kidx;
    logic        last;
    logic [15:0] addr;
  } col_t;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_rd[$];
  col_t        exp_col[$];
  int          done_cnt = 0;
  int          grp_seen = 0;
  int          rd_cnt = 0;
  int          resp_cnt = 0;
  bit          noise_en = 0;
  bit          no_resp = 0;

  // Distinct, address-dependent content per byte of a column.
  function automatic logic [CW-1:0] pat(input logic [AW-1:0] a);
    logic [CW-1:0] v;
    for (int i = 0; i < SR; i++) v[i*8 +: 8] = (a[7:0] + 8'(i * 3)) ^ a[15:8] ^ 8'h5A;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // SRAM model: one-cycle read latency.
  always @(posedge clk) if (sram_rd_en) sram_rd_data <= pat(sram_rd_addr);

  // Controller model: answers 4 cycles after the DRAIN cycle; optional noise
  // pulse during FETCH.
  always @(negedge clk) begin
    rc_valid = 1'b0;
    if (reset) begin
      resp_cnt = 0;
    end else begin
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) rc_valid = 1'b1;
      end
      if (rc_col_valid && rc_grp_last && !no_resp) resp_cnt = 4;
      if (noise_en && sram_rd_en && sram_rd_addr == 16'd1) rc_valid = 1'b1;
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    logic [15:0] ea;
    col_t        ec;
    if (!reset) begin
      if (sram_rd_en) begin
        ea = (exp_rd.size() != 0) ? exp_rd.pop_front() : 16'hFFFF;
        rd_cnt++;
        chk("rd_addr", 64'(sram_rd_addr), 64'(ea));
      end
      if (rc_col_valid) begin
        if (exp_col.size() != 0) ec = exp_col.pop_front();
        else ec = '{kidx: 8'hFF, last: 1'b1, addr: 16'hFFFF};
        chk("col_kidx", 64'(rc_kidx), 64'(ec.kidx));
        chk("col_last", 64'(rc_grp_last), 64'(ec.last));
        chk("col_lo", rc_lifm_column[63:0], pat(ec.addr) >> 0);
        chk("col_hi", rc_lifm_column[CW-1 -: 64], pat(ec.addr) >> (CW - 64));
        chk("col_enable", 64'(rc_enable), 64'd1);
        if (rc_grp_last) grp_seen++;
      end
      if (done) done_cnt++;
    end
  end

  task automatic push_exp(input int nk, input int nw);
    for (int w = 0; w < nw; w++)
      for (int k = 0; k < nk; k++) begin
        exp_rd.push_back(16'(w * nk + k));
        exp_col.push_back('{kidx: 8'(k), last: ((k % 3 == 2) || (k == nk - 1)),
                            addr: 16'(w * nk + k)});
      end
  endtask

  task automatic run(input int nk, input int nw, input bit poke);
    int d0, g0, r0;
    bit zero, seen;
    d0 = done_cnt; g0 = grp_seen; r0 = rd_cnt;
    zero = (nk == 0) || (nw == 0);
    if (!zero) push_exp(nk, nw);
    @(negedge clk); #1;
    start = 1'b1; num_kidx = 8'(nk); num_win = 8'(nw);
    @(negedge clk); #1;
    start = 1'b0; num_kidx = 8'hEE; num_win = 8'hEE;
    chk("busy_after_start", 64'(busy), 64'(!zero));
    chk("done_after_start", 64'(done), 64'(zero));
    if (poke) begin
      seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
        @(negedge clk); #1;
        seen = rc_enable && !sram_rd_en && !rc_col_valid;
      end
      chk("wait_found", 64'(seen), 64'd1);
      start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
    end
    seen = (done_cnt != d0);
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk); #1;
      seen = (done_cnt != d0);
    end
    chk("done_seen", 64'(seen), 64'd1);
    repeat (4) @(negedge clk);
    #1;
    chk("done_once", 64'(done_cnt - d0), 64'd1);
    chk("busy_idle", 64'(busy), 64'd0);
    chk("enable_idle", 64'(rc_enable), 64'd0);
    chk("rd_left", 64'(exp_rd.size()), 64'd0);
    chk("col_left", 64'(exp_col.size()), 64'd0);
    chk("groups", 64'(grp_seen - g0), zero ? 64'd0 : 64'(nw * ((nk + 2) / 3)));
    chk("reads", 64'(rd_cnt - r0), zero ? 64'd0 : 64'(nk * nw));
  endtask

  initial begin
    int d0;
    bit found;
    reset = 1'b1; start = 1'b0; num_kidx = '0; num_win = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rd_en", 64'(sram_rd_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_enable", 64'(rc_enable), 64'd0);
    chk("rst_col_valid", 64'(rc_col_valid), 64'd0);
    reset = 1'b0;

    run(3, 1, 0);
    run(7, 2, 0);
    run(0, 5, 0);

    // Abort during the second group, then restart cleanly.
    d0 = done_cnt;
    push_exp(7, 1);
    @(negedge clk); #1;
    start = 1'b1; num_kidx = 8'd7; num_win = 8'd1;
    @(negedge clk); #1;
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk); #1;
      found = sram_rd_en && (sram_rd_addr == 16'd4);
    end
    chk("abort_point", 64'(found), 64'd1);
    reset = 1'b1;
    @(negedge clk); #1;
    chk("abort_rd_en", 64'(sram_rd_en), 64'd0);
    chk("abort_addr", 64'(sram_rd_addr), 64'd0);
    chk("abort_col_valid", 64'(rc_col_valid), 64'd0);
    chk("abort_col", rc_lifm_column[63:0], 64'd0);
    chk("abort_enable", 64'(rc_enable), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    reset = 1'b0;
    exp_rd.delete();
    exp_col.delete();
    repeat (5) @(negedge clk);
    #1;
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    run(3, 1, 0);

    // rc_valid noise in FETCH and start during WAIT must be ignored.
    noise_en = 1;
    run(4, 1, 1);
    noise_en = 0;

`ifdef RC_SEQ_TIMEOUT_EN
    no_resp = 1;
    d0 = done_cnt;
    push_exp(1, 1);
    @(negedge clk); #1;
    start = 1'b1; num_kidx = 8'd1; num_win = 8'd1;
    @(negedge clk); #1;
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 70000 && !found; i++) begin
      @(negedge clk); #1;
      found = timeout_err;
    end
    chk("timeout_seen", 64'(found), 64'd1);
    repeat (10) @(negedge clk);
    #1;
    chk("timeout_done_once", 64'(done_cnt - d0), 64'd1);
    chk("timeout_sticky", 64'(timeout_err), 64'd1);
    chk("timeout_busy", 64'(busy), 64'd0);
    no_resp = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
